// File: rtl/regfile_dump_pkg.sv
// regfile_dump_pkg: shared FSM states, ASCII constants and hex-digit encoder for the register-file dump
package regfile_dump_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, one byte per valid while ready
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    // STOP ends one cycle early: the idle cycle that follows is the final stop-bit cycle
    localparam logic [CW-1:0] STOP_CNT = CW'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;

    ustate_t     r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_bit;
    logic [7:0]  r_shift;
    logic        r_tx;

    assign ready = r_state == U_IDLE;
    assign tx    = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= U_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                U_IDLE: begin
                    r_tx <= 1'b1;
                    if (valid) begin
                        r_shift <= data;
                        r_tx    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= U_START;
                    end
                end
                U_START: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= U_DATA;
                    end
                end
                U_DATA: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt <= '0;
                        if (r_bit == 4'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= U_STOP;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end
                end
                U_STOP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == STOP_CNT) begin
                        r_cnt   <= '0;
                        r_state <= U_IDLE;
                    end
                end
                default: r_state <= U_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/regfile_uart_dump.sv
// regfile_uart_dump: walks every register-file address and streams "AA:DD\r\n" hex records over UART
module regfile_uart_dump
    import regfile_dump_pkg::*;
#(
    parameter int N            = 4,
    parameter int W            = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] rd_addr,
    input  logic [W-1:0] rd_data,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int AD = (N + 3) / 4;
    localparam int DD = (W + 3) / 4;
    localparam int NB = AD + DD + 3;
    localparam int BW = $clog2(NB);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

    state_t        r_state;
    logic [N-1:0]  r_addr;
    logic [W-1:0]  r_snap;
    logic [BW-1:0] r_byte;
    logic          r_busy;
    logic          r_done;

    logic [4*AD-1:0] w_addr_pad;
    logic [4*DD-1:0] w_data_pad;
    logic [7:0]      w_rec [NB];
    logic            w_ready;

    assign w_addr_pad = (4*AD)'(r_addr);
    assign w_data_pad = (4*DD)'(r_snap);
    assign rd_addr    = r_addr;
    assign busy       = r_busy;
    assign done       = r_done;

    // The record is built only from the snapshot, so rd_data may move after FETCH
    always_comb begin
        for (int i = 0; i < AD; i++) w_rec[i] = hex2ascii(w_addr_pad[4*(AD-1-i) +: 4]);
        w_rec[AD] = ASCII_COLON;
        for (int i = 0; i < DD; i++) w_rec[AD+1+i] = hex2ascii(w_data_pad[4*(DD-1-i) +: 4]);
        w_rec[NB-2] = ASCII_CR;
        w_rec[NB-1] = ASCII_LF;
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (w_rec[r_byte]),
        .valid (r_state == LOAD),
        .ready (w_ready),
        .tx    (tx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_snap  <= '0;
            r_byte  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_state <= FETCH;
                    r_busy  <= 1'b1;
                end
                FETCH: begin
                    r_snap  <= rd_data;
                    r_state <= LOAD;
                end
                LOAD: r_state <= SEND;
                SEND: if (w_ready) begin
                    if (r_byte != LAST_BYTE) begin
                        r_byte  <= r_byte + 1'b1;
                        r_state <= LOAD;
                    end else begin
                        // Address increment wraps to 0 exactly when the last entry finishes
                        r_byte  <= '0;
                        r_addr  <= r_addr + 1'b1;
                        r_state <= (r_addr == '1) ? IDLE : FETCH;
                        r_busy  <= r_addr != '1;
                        r_done  <= r_addr == '1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_uart_dump.sv
// tb_regfile_uart_dump: directed vectors plus a UART decoder checking record content, framing and timing
module tb_regfile_uart_dump;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       tx, busy, done;
    logic       corrupt = 1'b0;
    bit         snap_en = 1'b0;
    bit         corrupt_done = 1'b0;

    assign rd_data = (corrupt && rd_addr == 4'd5) ? 8'hEE : {rd_addr, rd_addr};

    always #5 clk = ~clk;

    regfile_uart_dump #(.N(4), .W(8), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // UART decoder: every bit must hold for C cycles; bytes cut by reset are discarded
    logic [7:0] rx_b[$];
    int         rx_t[$];
    int         ferr = 0, started = 0, cur_t = 0;
    bit         d_ok, d_ab;
    logic [7:0] d_byte;
    logic       d_bv;

    always begin
        @(negedge clk);
        if (rst_n && tx === 1'b0) begin
            cur_t = cyc;
            started++;
            d_ok = 1; d_ab = 0; d_byte = '0; d_bv = 1'b0;
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < C; k++) begin
                    if (b != 0 || k != 0) @(negedge clk);
                    if (!rst_n) d_ab = 1;
                    if (k == 0) d_bv = tx;
                    else if (tx !== d_bv) d_ok = 0;
                    if (k == 0 && b >= 1 && b <= 8) d_byte[b-1] = tx;
                end
            end
            if (d_bv !== 1'b1) d_ok = 0;
            if (!d_ab) begin
                if (!d_ok) ferr++;
                rx_b.push_back(d_byte);
                rx_t.push_back(cur_t);
            end
        end
    end

    int   done_n = 0, done_t = 0;
    logic done_busy, done_prev_busy, prev_busy = 1'b0;
    logic [3:0] done_addr;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_n         <= done_n + 1;
            done_t         <= cyc;
            done_busy      <= busy;
            done_prev_busy <= prev_busy;
            done_addr      <= rd_addr;
        end
        prev_busy <= busy;
    end

    // Corrupts rd_data for address 5 two cycles after its FETCH
    always begin
        @(negedge clk);
        if (snap_en && !corrupt_done && busy && rd_addr == 4'd5) begin
            repeat (2) @(posedge clk);
            corrupt = 1'b1;
            while (rd_addr == 4'd5) @(negedge clk);
            corrupt = 1'b0;
            corrupt_done = 1'b1;
        end
    end

    typedef struct packed {
        logic [3:0]  addr;
        logic [47:0] bytes;
    } vec_t;
    vec_t tbl[6];

    function automatic logic [7:0] hx(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [7:0] exp_byte(input int a, input int j);
        logic [3:0] n = 4'(a);
        case (j)
            0: return hx(n);
            1: return 8'h3A;
            2, 3: return hx(n);
            4: return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    task automatic run_dump(input string tag, input bit mid_start);
        int s, rb, fb, db, n, bad_c, bad_s;
        bit got;
        rb = rx_b.size(); fb = ferr; db = done_n;
        @(negedge clk);
        s = cyc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_rise"}, busy, 1);
        got = 0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge clk);
            start = (mid_start && i == 1500);
            if (done === 1'b1) got = 1;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, got, 1);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, done, 0);
        n = rx_b.size() - rb;
        chk({tag, " byte_count"}, n, 96);
        chk({tag, " frame_errors"}, ferr - fb, 0);
        chk({tag, " done_pulses"}, done_n - db, 1);
        chk({tag, " done_busy_low"}, done_busy, 0);
        chk({tag, " busy_before_done"}, done_prev_busy, 1);
        chk({tag, " done_addr"}, done_addr, 0);
        if (n == 96) begin
            chk({tag, " first_start_latency"}, rx_t[rb] - s, 3);
            chk({tag, " done_after_last_stop"}, done_t - rx_t[rb+95], 4 * C * 10 / 4);
            bad_c = 0; bad_s = 0;
            for (int i = 0; i < 96; i++) begin
                if (rx_b[rb+i] !== exp_byte(i / 6, i % 6)) bad_c++;
                if (i > 0 && rx_t[rb+i] - rx_t[rb+i-1] != ((i % 6 == 0) ? 10*C + 2 : 10*C + 1)) bad_s++;
            end
            chk({tag, " content_errors"}, bad_c, 0);
            chk({tag, " spacing_errors"}, bad_s, 0);
            for (int v = 0; v < 6; v++) begin
                logic [47:0] got_rec;
                for (int j = 0; j < 6; j++) got_rec[47-8*j -: 8] = rx_b[rb + 6*tbl[v].addr + j];
                chk($sformatf("%s record_%0h", tag, tbl[v].addr), got_rec, tbl[v].bytes);
            end
        end
    endtask

    initial begin
        int base;
        tbl[0] = '{addr: 4'h0, bytes: {8'h30, 8'h3A, 8'h30, 8'h30, 8'h0D, 8'h0A}};
        tbl[1] = '{addr: 4'h3, bytes: {8'h33, 8'h3A, 8'h33, 8'h33, 8'h0D, 8'h0A}};
        tbl[2] = '{addr: 4'h5, bytes: {8'h35, 8'h3A, 8'h35, 8'h35, 8'h0D, 8'h0A}};
        tbl[3] = '{addr: 4'h9, bytes: {8'h39, 8'h3A, 8'h39, 8'h39, 8'h0D, 8'h0A}};
        tbl[4] = '{addr: 4'hA, bytes: {8'h41, 8'h3A, 8'h41, 8'h41, 8'h0D, 8'h0A}};
        tbl[5] = '{addr: 4'hF, bytes: {8'h46, 8'h3A, 8'h46, 8'h46, 8'h0D, 8'h0A}};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = (i == 3 || i == 6);
            chk($sformatf("reset_hold_%0d", i), {tx, busy, done, rd_addr}, {1'b1, 1'b0, 1'b0, 4'h0});
        end
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset", {tx, busy, done, rd_addr}, {1'b1, 1'b0, 1'b0, 4'h0});

        snap_en = 1'b1;
        run_dump("dump1", 1'b1);
        snap_en = 1'b0;
        chk("snapshot_corruption_applied", corrupt_done, 1);

        base = started;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000 && started < base + 21; i++) @(negedge clk);
        chk("byte20_reached", started - base >= 21, 1);
        while (cyc < cur_t + 13) @(negedge clk);
        chk("pre_reset_tx_low", tx, 0);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_mid_bit", {tx, busy, done, rd_addr}, {1'b1, 1'b0, 1'b0, 4'h0});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("no_resume_after_reset", {tx, busy, done, rd_addr}, {1'b1, 1'b0, 1'b0, 4'h0});

        run_dump("dump3", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
